// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit -- instruction-fetch stage of the RISC-V core.
//
// Holds the PC and delivers (pc, instruction) pairs to decode. On a fetch that
// cannot be served locally, one word is requested from the memory controller.
// The decode side can stall the stage, and a one-cycle jump_flag redirects the
// PC at any time.
//
// Build option (macro IF_ICACHE_EN):
//   defined   : direct-mapped instruction cache, one word per line,
//               2^INDEX_BITS lines, index = pc[INDEX_BITS+1:2],
//               tag = pc[ADDR_WIDTH-1:INDEX_BITS+2]. Hits deliver one
//               instruction per cycle.
//   undefined : no cache storage. Every fetch goes to memory and the matching
//               response is delivered directly. If decode is stalled, the
//               response is parked in a one-entry skid register.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             decode not ready: hold delivered outputs and PC
//   jump_flag         one-cycle redirect pulse, jump_target is the new PC
//   mem_req/mem_addr  word-fetch request (level) and its word address
//   mem_inst_valid    one-cycle pulse: mem_inst for mem_inst_addr is available
//   if_valid          if_pc/if_inst valid for decode
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    INDEX_BITS = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  jump_flag,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_inst_valid,
  input  logic [ADDR_WIDTH-1:0] mem_inst_addr,
  input  logic [INST_WIDTH-1:0] mem_inst,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [INST_WIDTH-1:0] if_inst
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_MISS  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  // The tag must keep at least one bit, otherwise aliasing cannot be detected.
  if (INDEX_BITS < 1 || INDEX_BITS > ADDR_WIDTH - 3) begin : g_bad_geometry
    $error("if_fetch_unit: INDEX_BITS out of range for ADDR_WIDTH");
  end

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic                  if_valid_q, if_valid_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [INST_WIDTH-1:0] if_inst_q, if_inst_d;
  logic                  resp_match_s;

  assign resp_match_s = mem_inst_valid && (mem_inst_addr == miss_addr_q);

  // Request drops combinationally in the response cycle so the controller
  // never sees a request it would treat as a second fetch.
  assign mem_req  = ((state_q == ST_MISS) || (state_q == ST_DRAIN)) && !mem_inst_valid;
  assign mem_addr = (state_q == ST_RUN) ? {ADDR_WIDTH{1'b0}} : miss_addr_q;

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;

`ifdef IF_ICACHE_EN
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  logic [LINES-1:0]      line_valid_q;
  logic [TAG_W-1:0]      line_tag_q  [LINES];
  logic [INST_WIDTH-1:0] line_data_q [LINES];
  logic [INDEX_BITS-1:0] rd_idx_s;
  logic [INDEX_BITS-1:0] wr_idx_s;
  logic                  hit_s;
  logic                  fill_s;

  assign rd_idx_s = pc_q[INDEX_BITS+1:2];
  assign wr_idx_s = mem_inst_addr[INDEX_BITS+1:2];
  // Responses are only meaningful while a fetch is outstanding; one arriving
  // in RUN belongs to a fetch abandoned by reset.
  assign fill_s   = mem_inst_valid && (state_q != ST_RUN);
  assign hit_s    = line_valid_q[rd_idx_s] &&
                    (line_tag_q[rd_idx_s] == pc_q[ADDR_WIDTH-1:INDEX_BITS+2]);

  // Line valid bits: cleared by reset, set by every accepted fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid_q <= {LINES{1'b0}};
    end else if (fill_s) begin
      line_valid_q[wr_idx_s] <= 1'b1;
    end
  end

  // Tag and data storage: RAM-like, no reset needed behind the valid bits.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      line_tag_q[wr_idx_s]  <= mem_inst_addr[ADDR_WIDTH-1:INDEX_BITS+2];
      line_data_q[wr_idx_s] <= mem_inst;
    end
  end

  // Next-state logic for the cached fetch path.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    case (state_q)
      ST_RUN: begin
        if (jump_flag) begin
          pc_d       = jump_target;
          if_valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (hit_s) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_inst_d  = line_data_q[rd_idx_s];
          pc_d       = pc_q + PC_STEP;
        end else begin
          miss_addr_d = pc_q;
          state_d     = ST_MISS;
          if_valid_d  = 1'b0;
        end
      end
      ST_MISS: begin
        if_valid_d = stall ? if_valid_q : 1'b0;
        if (resp_match_s) begin
          // The line is filled this cycle; the next RUN cycle hits on it.
          state_d = ST_RUN;
          pc_d    = jump_flag ? jump_target : pc_q;
        end else if (jump_flag) begin
          // The controller cannot abort, so wait out the response.
          pc_d    = jump_target;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_MISS;
        end
      end
      ST_DRAIN: begin
        if_valid_d = stall ? if_valid_q : 1'b0;
        pc_d       = jump_flag ? jump_target : pc_q;
        state_d    = mem_inst_valid ? ST_RUN : ST_DRAIN;
      end
      default: begin
        state_d    = ST_RUN;
        if_valid_d = 1'b0;
      end
    endcase
  end

`else
  logic                  skid_full_q, skid_full_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;

  // Skid register holding a response that arrived while decode was stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_full_q <= 1'b0;
      skid_pc_q   <= {ADDR_WIDTH{1'b0}};
      skid_inst_q <= {INST_WIDTH{1'b0}};
    end else begin
      skid_full_q <= skid_full_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  // Next-state logic for the uncached fetch path.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    skid_full_d = skid_full_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    case (state_q)
      ST_RUN: begin
        if (jump_flag) begin
          // A parked word belongs to the old path and is discarded.
          pc_d        = jump_target;
          if_valid_d  = 1'b0;
          skid_full_d = 1'b0;
        end else if (skid_full_q && !stall) begin
          if_valid_d  = 1'b1;
          if_pc_d     = skid_pc_q;
          if_inst_d   = skid_inst_q;
          skid_full_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else begin
          miss_addr_d = pc_q;
          state_d     = ST_MISS;
          if_valid_d  = 1'b0;
        end
      end
      ST_MISS: begin
        if_valid_d = stall ? if_valid_q : 1'b0;
        if (resp_match_s) begin
          state_d = ST_RUN;
          if (jump_flag) begin
            pc_d = jump_target;
          end else begin
            pc_d = miss_addr_q + PC_STEP;
            if (stall) begin
              skid_full_d = 1'b1;
              skid_pc_d   = miss_addr_q;
              skid_inst_d = mem_inst;
            end else begin
              if_valid_d = 1'b1;
              if_pc_d    = miss_addr_q;
              if_inst_d  = mem_inst;
            end
          end
        end else if (jump_flag) begin
          pc_d    = jump_target;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_MISS;
        end
      end
      ST_DRAIN: begin
        if_valid_d = stall ? if_valid_q : 1'b0;
        pc_d       = jump_flag ? jump_target : pc_q;
        state_d    = mem_inst_valid ? ST_RUN : ST_DRAIN;
      end
      default: begin
        state_d    = ST_RUN;
        if_valid_d = 1'b0;
      end
    endcase
  end
`endif

  // Fetch state, PC and delivered-instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      miss_addr_q <= {ADDR_WIDTH{1'b0}};
      if_valid_q  <= 1'b0;
      if_pc_q     <= {ADDR_WIDTH{1'b0}};
      if_inst_q   <= {INST_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// Self-checking bench for if_fetch_unit. A simple memory controller answers
// requests after a random latency; a behavioural model predicts the fetch
// unit's outputs every cycle. Works for both builds (IF_ICACHE_EN set or not).
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jump_flag;
  logic [31:0] jump_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_inst_valid;
  logic [31:0] mem_inst_addr;
  logic [31:0] mem_inst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .INDEX_BITS(6),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .jump_flag     (jump_flag),
    .jump_target   (jump_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_inst_valid(mem_inst_valid),
    .mem_inst_addr (mem_inst_addr),
    .mem_inst      (mem_inst),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst)
  );

  // Program memory contents: fixed function of the address (0x13 at 0).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // ---- reference model ----
  logic [31:0] m_pc, m_fetch, m_ipc, m_iinst;
  logic        m_vld;
  logic        m_waiting;    // a memory fetch is outstanding
  logic        m_abandoned;  // outstanding fetch no longer wanted (redirected)
  logic        park_full;
  logic [31:0] park_pc, park_inst;
  logic [31:0] cached_addr [int];  // line number -> word address held there

  // ---- memory controller ----
  logic        ctl_busy;
  logic [31:0] ctl_addr;
  int          ctl_wait;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd64);
  endfunction

  task automatic model_reset();
    m_pc        = 32'h0;
    m_fetch     = 32'h0;
    m_ipc       = 32'h0;
    m_iinst     = 32'h0;
    m_vld       = 1'b0;
    m_waiting   = 1'b0;
    m_abandoned = 1'b0;
    park_full   = 1'b0;
    park_pc     = 32'h0;
    park_inst   = 32'h0;
    cached_addr.delete();
  endtask

  task automatic deliver(input logic [31:0] a, input logic [31:0] d);
    m_vld   = 1'b1;
    m_ipc   = a;
    m_iinst = d;
  endtask

  // Advance the model across one clock edge using this cycle's inputs.
  task automatic model_update();
    logic resp;
    logic wanted;
    resp   = mem_inst_valid;
    wanted = resp && (mem_inst_addr == m_fetch);
    if (!m_waiting) begin
      if (jump_flag) begin
        m_pc      = jump_target;
        m_vld     = 1'b0;
        park_full = 1'b0;
`ifdef IF_ICACHE_EN
      end else if (stall) begin
        m_pc = m_pc;
      end else if (cached_addr.exists(line_of(m_pc)) && cached_addr[line_of(m_pc)] == m_pc) begin
        deliver(m_pc, mem_word(m_pc));
        m_pc = m_pc + 32'd4;
`else
      end else if (park_full && !stall) begin
        deliver(park_pc, park_inst);
        park_full = 1'b0;
      end else if (stall) begin
        m_pc = m_pc;
`endif
      end else begin
        m_fetch     = m_pc;
        m_waiting   = 1'b1;
        m_abandoned = 1'b0;
        m_vld       = 1'b0;
      end
    end else begin
      if (!stall) m_vld = 1'b0;
`ifdef IF_ICACHE_EN
      if (resp) cached_addr[line_of(mem_inst_addr)] = mem_inst_addr;
`endif
      if (m_abandoned) begin
        if (jump_flag) m_pc = jump_target;
        if (resp) m_waiting = 1'b0;
      end else if (wanted) begin
        m_waiting = 1'b0;
        if (jump_flag) begin
          m_pc = jump_target;
        end else begin
`ifndef IF_ICACHE_EN
          m_pc = m_fetch + 32'd4;
          if (stall) begin
            park_full = 1'b1;
            park_pc   = m_fetch;
            park_inst = mem_inst;
          end else begin
            deliver(m_fetch, mem_inst);
          end
`endif
        end
      end else if (jump_flag) begin
        m_pc        = jump_target;
        m_abandoned = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_vld});
    chk("if_pc", if_pc, m_ipc);
    chk("if_inst", if_inst, m_iinst);
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_waiting && !mem_inst_valid});
    chk("mem_addr", mem_addr, m_waiting ? m_fetch : 32'h0);
  endtask

  task automatic drive_ctl();
    if (ctl_busy && ctl_wait == 0) begin
      mem_inst_valid = 1'b1;
      mem_inst_addr  = ctl_addr;
      mem_inst       = mem_word(ctl_addr);
      ctl_busy       = 1'b0;
    end else begin
      mem_inst_valid = 1'b0;
      mem_inst_addr  = $urandom;
      mem_inst       = $urandom;
      if (ctl_busy) ctl_wait--;
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, advance model.
  task automatic step(input logic s, input logic j, input logic [31:0] t);
    stall       = s;
    jump_flag   = j;
    jump_target = t;
    drive_ctl();
    @(negedge clk);
    check_outputs();
    model_update();
    if (!ctl_busy && mem_req === 1'b1 && !mem_inst_valid) begin
      ctl_busy = 1'b1;
      ctl_addr = mem_addr;
      ctl_wait = int'($urandom_range(0, 3));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int n);
    rst            = 1'b1;
    stall          = 1'b0;
    jump_flag      = 1'b0;
    jump_target    = 32'h0;
    mem_inst_valid = 1'b0;
    mem_inst_addr  = 32'h0;
    mem_inst       = 32'h0;
    ctl_busy       = 1'b0;
    ctl_wait       = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    ctl_addr = 32'h0;
    model_reset();
    @(posedge clk);
    #1;
    reset_dut(3);

    // First fetch from RESET_PC, then a tight loop 0x0..0xC with a jump back.
    run(12);
    for (int i = 0; i < 80; i++) step(1'b0, (m_pc == 32'h10) && !m_waiting, 32'h0);

    // Redirect while a fetch of 0x40 is outstanding.
    step(1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h100);
    run(25);

    // Stall held on a delivered instruction, then released.
    for (int i = 0; i < 40 && !m_vld; i++) step(1'b0, 1'b0, 32'h0);
    repeat (5) step(1'b1, 1'b0, 32'h0);
    run(10);

    // Aliasing lines: 0x000 and 0x100 share an index.
    step(1'b0, 1'b1, 32'h000);
    run(15);
    step(1'b0, 1'b1, 32'h100);
    run(15);
    step(1'b0, 1'b1, 32'h000);
    run(15);

    // Response arriving under stall, held across several cycles.
    step(1'b0, 1'b1, 32'h20);
    for (int i = 0; i < 10 && !m_waiting; i++) step(1'b0, 1'b0, 32'h0);
    repeat (8) step(1'b1, 1'b0, 32'h0);
    run(12);

    // Reset in the middle of a fetch.
    step(1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 10 && !m_waiting; i++) step(1'b0, 1'b0, 32'h0);
    reset_dut(1);
    run(15);

    // Wrap of the PC at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    run(30);

    // Random stall / jump traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF8 : {22'd0, 8'($urandom_range(0, 127)), 2'b00};
      step($urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
